// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
// pipelined_addsub_if : operand/result handshake bundle for pipelined_addsub
// Revision: 1.0
// ============================================================================
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, overflow, zero
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// pipelined_addsub : skewed, carry-chained add/sub pipeline, CHUNK bits/stage
// Revision: 1.0
// ============================================================================
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  wire                clk,
  input  wire                rst,
  pipelined_addsub_if.slave  bus
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  logic [WIDTH-1:0] w_beff;
  logic             w_c0;
  logic             w_stall;
  logic [CHUNK:0]   w_slice;

  // Stage k sees these inputs: operands and lower partial sums from stage k-1.
  logic [WIDTH-1:0] w_a_in [STAGES];
  logic [WIDTH-1:0] w_b_in [STAGES];
  logic [WIDTH-1:0] w_s_in [STAGES];
  logic             w_c_in [STAGES];

  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             v_d [STAGES];
  logic             overflow_d;
  logic             zero_d;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             overflow_q;
  logic             zero_q;

  assign w_stall       = v_q[LAST] && !bus.out_ready;
  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = v_q[LAST];
  assign bus.s         = s_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  always_comb begin
    w_beff  = bus.sub ? ~bus.b : bus.b;
    w_c0    = bus.cin ^ bus.sub;
    w_slice = '0;

    w_a_in[0] = bus.a;
    w_b_in[0] = w_beff;
    w_s_in[0] = '0;
    w_c_in[0] = w_c0;
    v_d[0]    = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k] = a_q[k-1];
      w_b_in[k] = b_q[k-1];
      w_s_in[k] = s_q[k-1];
      w_c_in[k] = c_q[k-1];
      v_d[k]    = v_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      w_slice = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
              + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, w_c_in[k]};
      s_d[k]                   = w_s_in[k];
      s_d[k][k*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
      c_d[k]                   = w_slice[CHUNK];
    end

    // Flags derive from the complete sum, which only exists in the final stage.
    overflow_d = (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1])
              && (s_d[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);
    zero_d     = (s_d[LAST] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (!w_stall) begin
      for (int k = 0; k < LAST; k++) begin
        a_q[k] <= w_a_in[k];
        b_q[k] <= w_b_in[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
      end
      // Bubbles leave the visible result untouched.
      if (v_d[LAST]) begin
        s_q[LAST]  <= s_d[LAST];
        c_q[LAST]  <= c_d[LAST];
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// tb_pipelined_addsub : scoreboard bench over three pipelined_addsub configs
// Revision: 1.0
// ============================================================================
module tb_pipelined_addsub;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
    int         edge_n;
    bit         chk;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv   [3];
  logic [7:0] ia   [3];
  logic [7:0] ib   [3];
  logic       icin [3];
  logic       isub [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic [7:0] os   [3];
  logic       oc   [3];
  logic       oo   [3];
  logic       oz   [3];

  item_t sb [3][$];
  item_t mon_it;
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: WIDTH=4 CHUNK=4 (1 stage); dut1: 8/4 (2 stages); dut2: 8/2 (4 stages)
  pipelined_addsub_if #(.WIDTH(4)) bus0 ();
  pipelined_addsub_if #(.WIDTH(8)) bus1 ();
  pipelined_addsub_if #(.WIDTH(8)) bus2 ();

  pipelined_addsub #(.WIDTH(4), .CHUNK(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pipelined_addsub #(.WIDTH(8), .CHUNK(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipelined_addsub #(.WIDTH(8), .CHUNK(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.in_valid  = iv[0];
  assign bus0.a         = ia[0][3:0];
  assign bus0.b         = ib[0][3:0];
  assign bus0.cin       = icin[0];
  assign bus0.sub       = isub[0];
  assign bus0.out_ready = ordy[0];
  assign ir[0] = bus0.in_ready;
  assign ov[0] = bus0.out_valid;
  assign os[0] = {4'b0000, bus0.s};
  assign oc[0] = bus0.cout;
  assign oo[0] = bus0.overflow;
  assign oz[0] = bus0.zero;

  assign bus1.in_valid  = iv[1];
  assign bus1.a         = ia[1];
  assign bus1.b         = ib[1];
  assign bus1.cin       = icin[1];
  assign bus1.sub       = isub[1];
  assign bus1.out_ready = ordy[1];
  assign ir[1] = bus1.in_ready;
  assign ov[1] = bus1.out_valid;
  assign os[1] = bus1.s;
  assign oc[1] = bus1.cout;
  assign oo[1] = bus1.overflow;
  assign oz[1] = bus1.zero;

  assign bus2.in_valid  = iv[2];
  assign bus2.a         = ia[2];
  assign bus2.b         = ib[2];
  assign bus2.cin       = icin[2];
  assign bus2.sub       = isub[2];
  assign bus2.out_ready = ordy[2];
  assign ir[2] = bus2.in_ready;
  assign ov[2] = bus2.out_valid;
  assign os[2] = bus2.s;
  assign oc[2] = bus2.cout;
  assign oo[2] = bus2.overflow;
  assign oz[2] = bus2.zero;

  function automatic int stg(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, required %0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  // Presents one operation (called just after a rising edge) and records its
  // hand-computed result once the handshake is seen to complete.
  task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic eo, input logic ez,
                      input bit chk);
    int    n;
    item_t it;
    iv[d] = 1'b1; ia[d] = a; ib[d] = b; icin[d] = cin; isub[d] = sub;
    n = 0;
    @(negedge clk);
    while (!ir[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ir[d]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: in_ready stuck at 0, required 1", d);
    end else begin
      it = '{s: es, c: ec, o: eo, z: ez, edge_n: cyc + stg(d), chk: chk};
      sb[d].push_back(it);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_pending", 0, 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && ordy[d]) begin
          if (sb[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out dut%0d: got out_valid=1 s=%0h, required no result", d, os[d]);
          end else begin
            mon_it = sb[d].pop_front();
            check("sum",      d, 32'(os[d]), 32'(mon_it.s));
            check("cout",     d, 32'(oc[d]), 32'(mon_it.c));
            check("overflow", d, 32'(oo[d]), 32'(mon_it.o));
            check("zero",     d, 32'(oz[d]), 32'(mon_it.z));
            if (mon_it.chk) check("latency_edge", d, 32'(cyc), 32'(mon_it.edge_n));
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ia[d] = 8'h00; ib[d] = 8'h00;
      icin[d] = 1'b0; isub[d] = 1'b0; ordy[d] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", d, 32'(ov[d]), 32'd0);
      check("rst_s",         d, 32'(os[d]), 32'd0);
      check("rst_cout",      d, 32'(oc[d]), 32'd0);
      check("rst_overflow",  d, 32'(oo[d]), 32'd0);
      check("rst_zero",      d, 32'(oz[d]), 32'd0);
      check("rst_in_ready",  d, 32'(ir[d]), 32'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    check("release_in_ready", 2, 32'(ir[2]), 32'd1);
    @(posedge clk);
    #1;

    // 4-bit single-stage: 1010+1010+1 = 1_0101, signed overflow
    send(0, 8'h0A, 8'h0A, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1);

    // 8-bit, two stages
    send(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    send(1, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send(1, 8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    send(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
    send(1, 8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0, 1'b1);
    send(1, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);

    // Bubble between two ops: exact arrival edges pin the 1,0,1 pattern.
    send(1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    send(1, 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // 4-stage stream with downstream backpressure for four cycles.
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(2, 8'(i), 8'(16 * i), 1'b0, 1'b0, 8'(17 * i), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        ordy[2] = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_out_valid", 2, 32'(ov[2]), 32'd1);
          check("stall_in_ready",  2, 32'(ir[2]), 32'd0);
          check("stall_s_hold",    2, 32'(os[2]), 32'h11);
        end
        @(posedge clk);
        #1;
        ordy[2] = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with three operations in flight.
    ordy[2] = 1'b0;
    send(2, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    send(2, 8'h02, 8'h02, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    send(2, 8'h03, 8'h03, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_valid", 2, 32'(ov[2]), 32'd1);
    sb[2].delete();
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 2, 32'(ov[2]), 32'd0);
    check("async_rst_s",         2, 32'(os[2]), 32'd0);
    check("async_rst_cout",      2, 32'(oc[2]), 32'd0);
    check("async_rst_overflow",  2, 32'(oo[2]), 32'd0);
    check("async_rst_zero",      2, 32'(oz[2]), 32'd0);
    check("async_rst_in_ready",  2, 32'(ir[2]), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    ordy[2] = 1'b1;
    check("post_rst_in_ready", 2, 32'(ir[2]), 32'd1);
    send(2, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
